// File: rtl/mdsa_out_serializer.sv
// Captures the sorted N*N frame on a rising edge of output_enable and streams it one word per cycle
// over valid/ready. Build option: define MDSA_SNAKE_ORDER_EN for boustrophedon (shear-sort) readout order.
//
//   state  | meaning
//   IDLE   | no frame held, waiting for an output_enable rising edge
//   STREAM | frame held, presenting word pos until the last one is accepted
module mdsa_out_serializer #(
  parameter int N  = 8,
  parameter int DW = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [N*N*DW-1:0]         data_in,
  input  logic                      output_enable,
  output logic [DW-1:0]             m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_last,
  output logic [$clog2(N*N)-1:0]    m_index,
  output logic                      busy,
  output logic                      overrun
);

  localparam int WORDS = N * N;
  localparam int IW    = $clog2(WORDS);
  localparam logic [IW-1:0] LAST_POS = IW'(WORDS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          oe_q;
  logic [IW-1:0] pos;
  logic [IW-1:0] src_idx;
  logic [DW-1:0] frame_q [WORDS];

  logic oe_rise;
  logic at_last;
  logic xfer;
  logic capture;
  logic drop;

  assign oe_rise = output_enable & ~oe_q;
  assign at_last = (pos == LAST_POS);
  assign xfer    = en & m_valid & m_ready;
  // A rise coincident with the final accepted word chains straight into the next frame.
  assign capture = en & oe_rise & ((state == IDLE) | (xfer & at_last));
  assign drop    = en & oe_rise & (state == STREAM) & ~(xfer & at_last);

`ifdef MDSA_SNAKE_ORDER_EN
  logic [IW-1:0] row;
  logic [IW-1:0] col;
  always_comb begin
    row     = pos / IW'(N);
    col     = pos % IW'(N);
    src_idx = row[0] ? (row * IW'(N) + (IW'(N - 1) - col)) : pos;
  end
`else
  assign src_idx = pos;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = STREAM;
      STREAM:  if (xfer && at_last && !capture) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_index = '0;
    m_data  = '0;
    busy    = 1'b0;
    if (state == STREAM) begin
      busy    = 1'b1;
      m_valid = en;
      m_last  = at_last;
      m_index = src_idx;
      m_data  = frame_q[src_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oe_q    <= 1'b0;
      pos     <= '0;
      overrun <= 1'b0;
    end else if (en) begin
      oe_q <= output_enable;
      if (capture)   pos <= '0;
      else if (xfer) pos <= at_last ? '0 : pos + 1'b1;
      if (drop) overrun <= 1'b1;
    end
  end

  // Frame storage needs no reset; outputs are masked outside STREAM.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < WORDS; i++) frame_q[i] <= data_in[i*DW +: DW];
    end
  end

endmodule

// File: doc/mdsa_out_serializer.md
# mdsa_out_serializer

Downstream stage of the MDSA sorter: captures the sorted N×N frame from the sorter's `data_out` when the sorter raises `output_enable`, then streams it one DW-bit word per cycle over a valid/ready interface. It decouples the wide parallel sorter result from narrow consumers such as a DMA or output FIFO, and flags frames lost because the stream was still busy.

## Interface
- `N`, 8, grid dimension; frame holds N*N words.
- `DW`, 32, word width in bits.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `en`  in  1  global enable; low freezes all state.
- `data_in`  in  N*N*DW  sorted frame from the sorter; word i occupies bits [(i+1)*DW-1 : i*DW].
- `output_enable`  in  1  sorter result-valid level; rising edge requests a capture.
- `m_data`  out  DW  current output word.
- `m_valid`  out  1  `m_data` valid.
- `m_ready`  in  1  consumer accepts the word.
- `m_last`  out  1  high with the final word of a frame.
- `m_index`  out  clog2(N*N)  frame index of the word on `m_data`.
- `busy`  out  1  frame held, stream not finished.
- `overrun`  out  1  sticky; a capture request was dropped.

## Operation
- Registers: `oe_q` (previous `output_enable`), frame buffer N*N*DW, position counter `pos` (0..N*N-1), state, `overrun`.
- `oe_rise` = `output_enable & ~oe_q`; `oe_q` updates only when `en`=1.
- States: IDLE, STREAM.
- IDLE: on `en & oe_rise`, latch `data_in`, set `pos`=0, go to STREAM.
- STREAM: `m_valid`=1 (gated by `en`). Transfer = `en & m_valid & m_ready`. On transfer with `pos`<N*N-1, increment `pos`. On transfer with `pos`=N*N-1 (last), return to IDLE, unless `oe_rise` in the same cycle: then recapture, `pos`=0, stay in STREAM (no bubble).
- `oe_rise` in STREAM other than on the last transfer: frame ignored, `overrun` set to 1. Cleared only by `rst`.
- `m_index` = source index of `pos` (see Configuration); `m_data` = buffer word `m_index`; `m_last` = (`pos`=N*N-1) & STREAM.
- `busy` = (state = STREAM).
- While stalled (`m_ready`=0), `m_data`, `m_index`, `m_last` are held stable.
- `en`=0: no capture, no transfer, `pos` and state held; `m_valid` reads 0 and resumes on `en`=1 with the same word.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `m_last`=0, `m_index`=0, `busy`=0, `overrun`=0, `oe_q`=0, state IDLE, buffer contents don't-care.
- Latency: `oe_rise` sampled at edge t; word 0 is valid after edge t, so accepted no earlier than edge t+1.
- Throughput: 1 word per cycle with `m_ready` held high. A full frame takes N*N cycles; `m_last` appears on the (N*N)-th valid cycle.
- `output_enable` held high for many cycles yields exactly one capture.
- `rst` mid-stream aborts immediately. The frame is discarded and all outputs return to reset values.
- `data_in` is sampled only on the capture edge; later changes to it have no effect on the frame being streamed.

## Configuration
- `MDSA_SNAKE_ORDER_EN` defined: snake (boustrophedon) readout. With r=`pos`/N and c=`pos`%N, the source index is r*N+c for even r and r*N+(N-1-c) for odd r. This gives shear-sort ascending order.
- Undefined: linear readout, source index = `pos`.

## Test plan
- Reset, then load frame word i = 1000+i, pulse `output_enable`, hold `m_ready`=1 -> 64 consecutive words 1000..1063 with `m_index` 0..63; `m_last` only on 1063; `busy` falls after the last transfer.
- Same frame, `m_ready` toggling 1,0,0,1... -> no word lost or duplicated; data stable across stalls.
- `MDSA_SNAKE_ORDER_EN` defined, same frame -> positions 7,8,9 present 1007,1015,1014; `m_index` 7,15,14; final word 1056 (index 56).
- Second `oe_rise` at word 10 -> ignored, `overrun`=1, stream completes first frame. A rising edge coincident with the last transfer -> new frame's word 0 appears on the next cycle, `overrun` unchanged.
- `rst` asserted at word 20, then released -> all outputs 0, state IDLE; a new capture restarts at word 0.
- `en`=0 for 5 cycles mid-stream -> `m_valid`=0 and `pos` frozen; resumes at the same word, total of 64 transfers.
